// File: rtl/window_3x3_gen.sv
// window_3x3_gen: turns a raster-order pixel stream into a sliding 3x3 neighbourhood
// for the downstream median stage.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    pixel qualifier; a pixel is accepted on every edge with in_valid=1
//   in_sof      start of frame; with in_valid=1 forces the pixel to position (0,0)
//   in_pixel    pixel data in raster order
//   p11..p13    window top row    (row y-2, cols x-2..x)
//   p21..p23    window middle row (row y-1)
//   p31..p33    window bottom row (row y)
//   win_valid   one-cycle qualifier for the window centred on (x-1,y-1)
//   frame_done  one-cycle pulse after the last pixel of the frame is accepted
module window_3x3_gen #(
   parameter int unsigned width = 8,
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [width-1:0] in_pixel,
   output logic [width-1:0] p11,
   output logic [width-1:0] p12,
   output logic [width-1:0] p13,
   output logic [width-1:0] p21,
   output logic [width-1:0] p22,
   output logic [width-1:0] p23,
   output logic [width-1:0] p31,
   output logic [width-1:0] p32,
   output logic [width-1:0] p33,
   output logic             win_valid,
   output logic             frame_done
);

   localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
   localparam logic [XW-1:0] X_MIN  = XW'(2);
   localparam logic [YW-1:0] Y_MIN  = YW'(2);

   // Raster position of the next expected pixel
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   // Position actually assigned to the pixel on the input (in_sof overrides)
   logic [XW-1:0] pos_x_c;
   logic [YW-1:0] pos_y_c;

   // Line buffers: lb0 holds row y-1, lb1 holds row y-2; never reset
   logic [width-1:0] lb0_q [IMG_W];
   logic [width-1:0] lb1_q [IMG_W];

   // Column entering the window from the right
   logic [width-1:0] col_top_c;
   logic [width-1:0] col_mid_c;

   // Window registers, row-major
   logic [width-1:0] p11_q, p12_q, p13_q;
   logic [width-1:0] p21_q, p22_q, p23_q;
   logic [width-1:0] p31_q, p32_q, p33_q;
   logic [width-1:0] p11_d, p12_d, p13_d;
   logic [width-1:0] p21_d, p22_d, p23_d;
   logic [width-1:0] p31_d, p32_d, p33_d;

   logic win_valid_q, win_valid_d;
   logic frame_done_q, frame_done_d;

   // Pixel position: start-of-frame resynchronises to the origin
   always_comb begin
      pos_x_c = x_q;
      pos_y_c = y_q;
      if (in_sof) begin
         pos_x_c = '0;
         pos_y_c = '0;
      end
   end

   // Next raster position after an accepted pixel
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (in_valid) begin
         if (pos_x_c == X_LAST) begin
            x_d = '0;
            if (pos_y_c == Y_LAST) begin
               y_d = '0;
            end else begin
               y_d = pos_y_c + YW'(1);
            end
         end else begin
            x_d = pos_x_c + XW'(1);
            y_d = pos_y_c;
         end
      end
   end

   // Line buffer read happens before the same-edge write
   assign col_top_c = lb1_q[pos_x_c];
   assign col_mid_c = lb0_q[pos_x_c];

   // Window shift and qualifiers
   always_comb begin
      p11_d        = p11_q;
      p12_d        = p12_q;
      p13_d        = p13_q;
      p21_d        = p21_q;
      p22_d        = p22_q;
      p23_d        = p23_q;
      p31_d        = p31_q;
      p32_d        = p32_q;
      p33_d        = p33_q;
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      if (in_valid) begin
         p11_d = p12_q;
         p12_d = p13_q;
         p13_d = col_top_c;
         p21_d = p22_q;
         p22_d = p23_q;
         p23_d = col_mid_c;
         p31_d = p32_q;
         p32_d = p33_q;
         p33_d = in_pixel;
         // Border rows/columns carry stale or wrapped data and are masked here
         win_valid_d  = (pos_x_c >= X_MIN) && (pos_y_c >= Y_MIN);
         frame_done_d = (pos_x_c == X_LAST) && (pos_y_c == Y_LAST);
      end
   end

   // Position counters
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   // Line buffer storage
   always_ff @(posedge clk) begin
      if (in_valid) begin
         lb1_q[pos_x_c] <= col_mid_c;
         lb0_q[pos_x_c] <= in_pixel;
      end
   end

   // Window and qualifier registers
   always_ff @(posedge clk) begin
      if (rst) begin
         p11_q        <= '0;
         p12_q        <= '0;
         p13_q        <= '0;
         p21_q        <= '0;
         p22_q        <= '0;
         p23_q        <= '0;
         p31_q        <= '0;
         p32_q        <= '0;
         p33_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         p11_q        <= p11_d;
         p12_q        <= p12_d;
         p13_q        <= p13_d;
         p21_q        <= p21_d;
         p22_q        <= p22_d;
         p23_q        <= p23_d;
         p31_q        <= p31_d;
         p32_q        <= p32_d;
         p33_q        <= p33_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign p11        = p11_q;
   assign p12        = p12_q;
   assign p13        = p13_q;
   assign p21        = p21_q;
   assign p22        = p22_q;
   assign p23        = p23_q;
   assign p31        = p31_q;
   assign p32        = p32_q;
   assign p33        = p33_q;
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Testbench for window_3x3_gen: a frame-memory reference model predicts every
// window; literal windows from the test plan pin the model and the DUT.
module tb_window_3x3_gen;

   localparam int W  = 5;
   localparam int H  = 4;
   localparam int PW = 8;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_sof;
   logic [PW-1:0] in_pixel;
   logic [PW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
   logic          win_valid;
   logic          frame_done;

   window_3x3_gen #(.width(PW), .IMG_W(W), .IMG_H(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .in_pixel   (in_pixel),
      .p11        (p11),
      .p12        (p12),
      .p13        (p13),
      .p21        (p21),
      .p22        (p22),
      .p23        (p23),
      .p31        (p31),
      .p32        (p32),
      .p33        (p33),
      .win_valid  (win_valid),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model: whole-frame memory ----------------
   logic [PW-1:0] mem [H][W];
   int            mx, my;
   int            acc_cnt;
   bit            started;
   bit            exp_known;
   bit            exp_wv, exp_fd;
   logic [71:0]   exp_win;

   initial begin
      mx = 0; my = 0; acc_cnt = 0; started = 0;
      exp_known = 0; exp_wv = 0; exp_fd = 0; exp_win = '0;
   end

   always @(posedge clk) begin
      int px, py;
      if (rst) begin
         started   = 1;
         mx        = 0;
         my        = 0;
         exp_win   = '0;
         exp_wv    = 0;
         exp_fd    = 0;
         exp_known = 1;
      end else if (in_valid) begin
         px = in_sof ? 0 : mx;
         py = in_sof ? 0 : my;
         mem[py][px] = in_pixel;
         acc_cnt++;
         exp_fd = (px == W - 1) && (py == H - 1);
         if (px >= 2 && py >= 2) begin
            exp_wv    = 1;
            exp_known = 1;
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  exp_win[71 - 8*(3*r + c) -: 8] = mem[py-2+r][px-2+c];
         end else begin
            exp_wv    = 0;
            exp_known = 0;
         end
         mx = px + 1;
         my = py;
         if (mx == W) begin
            mx = 0;
            my = (py + 1 == H) ? 0 : py + 1;
         end
      end else begin
         exp_wv = 0;
         exp_fd = 0;
      end
   end

   // ---------------- checking ----------------
   int          checks;
   int          errors;
   int          fd_cnt;
   logic [71:0] wq [$];
   int          aq [$];
   bit          fq [$];

   function automatic logic [71:0] dut_win();
      return {p11, p12, p13, p21, p22, p23, p31, p32, p33};
   endfunction

   // Window of a clean frame (pixel = 10*y+x) for the i-th interior pixel
   function automatic logic [71:0] clean_win(input int i);
      logic [71:0] w;
      int x, y;
      x = 2 + (i % 3);
      y = 2 + (i / 3);
      w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[71 - 8*(3*r + c) -: 8] = 8'(10*(y-2+r) + (x-2+c));
      return w;
   endfunction

   function automatic logic [71:0] qw(input int i);
      if (i < int'(wq.size())) return wq[i];
      return {72{1'b1}};
   endfunction

   function automatic int qa(input int i);
      if (i < int'(aq.size())) return aq[i];
      return -1000;
   endfunction

   function automatic int qf(input int i);
      if (i < int'(fq.size())) return int'(fq[i]);
      return -1;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic chk_win(input string name, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Per-cycle comparison against the model, at the falling edge
   task automatic compare_now();
      if (started) begin
         chk("win_valid", int'(win_valid), int'(exp_wv));
         chk("frame_done", int'(frame_done), int'(exp_fd));
         if (exp_known) chk_win("window", dut_win(), exp_win);
         if (win_valid === 1'b1) begin
            wq.push_back(dut_win());
            aq.push_back(acc_cnt);
            fq.push_back(frame_done);
         end
         if (frame_done === 1'b1) fd_cnt++;
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic step(input bit v, input bit sof, input logic [PW-1:0] pix, input bit r);
      @(negedge clk);
      compare_now();
      rst      = r;
      in_valid = v;
      in_sof   = sof;
      in_pixel = pix;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 8'($urandom), 0);
   endtask

   task automatic do_reset();
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      chk_win("reset_window", dut_win(), 72'd0);
      chk("reset_win_valid", int'(win_valid), 0);
      chk("reset_frame_done", int'(frame_done), 0);
   endtask

   // Send n raster pixels with random gaps; in_sof on each frame start when requested
   task automatic run_pix(input int n, input int gap_pct, input bit use_sof);
      for (int k = 0; k < n; k++) begin
         int x, y;
         x = k % W;
         y = (k / W) % H;
         while (int'($urandom_range(99)) < gap_pct)
            step(0, 1'($urandom), 8'($urandom), 0);
         step(1, use_sof && (k % (W*H) == 0), 8'(10*y + x), 0);
      end
   endtask

   task automatic check_clean(input string name, input int wb, input int n);
      for (int i = 0; i < n; i++)
         chk_win(name, qw(wb + i), clean_win(i % 6));
   endtask

   logic [71:0] lit_first;
   logic [71:0] lit_23;
   logic [71:0] lit_43;

   initial begin
      int wb, ab, fb;
      rst = 0; in_valid = 0; in_sof = 0; in_pixel = '0;
      checks = 0; errors = 0; fd_cnt = 0;
      lit_first = {8'd0,  8'd1,  8'd2,  8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22};
      lit_23    = {8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22, 8'd30, 8'd31, 8'd32};
      lit_43    = {8'd12, 8'd13, 8'd14, 8'd22, 8'd23, 8'd24, 8'd32, 8'd33, 8'd34};

      // 1 + 2: clean frame, first window, count, row wrap, frame_done
      do_reset();
      wb = wq.size(); ab = acc_cnt; fb = fd_cnt;
      run_pix(20, 0, 1);
      idle(2);
      chk("s1_count", int'(wq.size()) - wb, 6);
      chk("s1_first_at", qa(wb) - ab, 13);
      chk_win("s1_first", qw(wb), lit_first);
      chk("s1_frame_done", fd_cnt - fb, 1);
      check_clean("s1_seq", wb, 6);
      chk("s2_last_row2_at", qa(wb + 2) - ab, 15);
      chk("s2_first_row3_at", qa(wb + 3) - ab, 18);
      chk_win("s2_win_23", qw(wb + 3), lit_23);
      chk_win("s2_win_43", qw(wb + 5), lit_43);
      chk("s2_fd_with_last", qf(wb + 5), 1);
      chk("s2_no_fd_earlier", qf(wb + 4), 0);

      // 3: random gaps
      do_reset();
      wb = wq.size(); fb = fd_cnt;
      run_pix(20, 50, 1);
      idle(3);
      chk("s3_count", int'(wq.size()) - wb, 6);
      chk("s3_frame_done", fd_cnt - fb, 1);
      check_clean("s3_seq", wb, 6);

      // 4: in_sof arrives at what would have been (3,2)
      do_reset();
      run_pix(13, 0, 1);
      idle(1);
      wb = wq.size(); ab = acc_cnt;
      run_pix(20, 0, 1);
      idle(2);
      chk("s4_count", int'(wq.size()) - wb, 6);
      chk("s4_first_at", qa(wb) - ab, 13);
      chk_win("s4_first", qw(wb), lit_first);

      // 5: reset mid-frame, next frame without in_sof
      do_reset();
      run_pix(14, 0, 1);
      do_reset();
      wb = wq.size(); fb = fd_cnt;
      run_pix(20, 0, 0);
      idle(2);
      chk("s5_count", int'(wq.size()) - wb, 6);
      chk("s5_frame_done", fd_cnt - fb, 1);
      check_clean("s5_seq", wb, 6);

      // 6: two back-to-back frames
      do_reset();
      wb = wq.size(); fb = fd_cnt;
      run_pix(40, 0, 1);
      idle(2);
      chk("s6_count", int'(wq.size()) - wb, 12);
      chk("s6_frame_done", fd_cnt - fb, 2);
      chk_win("s6_f2_first", qw(wb + 6), lit_first);
      check_clean("s6_seq", wb, 12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Upstream neighbour of the 3x3 median stage: turns a raster-order pixel stream into a sliding 3x3 neighbourhood.
- Buffers the two previous image lines and a 3-column shift window.
- Presents nine registered pixels p11..p33 with a qualifying win_valid, one window per accepted interior pixel, ready for direct connection to the median stage's nine inputs.
- No backpressure: the downstream median stage is purely combinational and always accepts.

Parameters:
- width, 8, pixel bit width (matches median stage).
- IMG_W, 640, pixels per line (>=3).
- IMG_H, 480, lines per frame (>=3).

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  pixel qualifier; pixel accepted on a clk edge with in_valid=1.
- in_sof  input  1  start-of-frame; meaningful only with in_valid=1; marks the accepted pixel as (x=0,y=0).
- in_pixel  input  width  pixel data, raster order (left->right, top->bottom).
- p11,p12,p13  output  width  window top row, cols x-2,x-1,x (row y-2).
- p21,p22,p23  output  width  window middle row (row y-1).
- p31,p32,p33  output  width  window bottom row (row y).
- win_valid  output  1  window outputs valid this cycle; window centre is (x-1,y-1).
- frame_done  output  1  one-cycle pulse after the last pixel (IMG_W-1,IMG_H-1) is accepted.

Behaviour:
- Reset (rst=1 at a clk edge): x=0, y=0, all p** = 0, win_valid=0, frame_done=0. Line buffers are not cleared; their stale data is never exposed because of the y>=2 gating.
- Position counters:
  - x: 0..IMG_W-1; y: 0..IMG_H-1.
  - The pixel's position is (0,0) if in_sof=1, else the current (x,y).
  - After acceptance: x increments; at IMG_W-1, x wraps to 0 and y increments; at (IMG_W-1,IMG_H-1), both wrap to 0.
- Two line buffers, depth IMG_W, addressed by x: lb0 holds row y-1, lb1 holds row y-2. On an accepted pixel at column x:
  - new right column = {lb1[x], lb0[x], in_pixel}.
  - lb1[x] <= lb0[x]; lb0[x] <= in_pixel (read-before-write, same edge).
- Window shift, on an accepted pixel only:
  - p11<=p12, p12<=p13, p13<=lb1[x].
  - p21<=p22, p22<=p23, p23<=lb0[x].
  - p31<=p32, p32<=p33, p33<=in_pixel.
- Latency: window registered one clk after the accepting edge.
- win_valid = 1 for exactly one cycle after accepting a pixel with y>=2 and x>=2; otherwise 0.
- Per frame: exactly (IMG_W-2)*(IMG_H-2) windows. No border padding; border pixels produce no window.
- in_valid=0: all p** hold their values; win_valid=0; counters and buffers hold.
- in_sof asserted mid-frame: the pixel is taken as (0,0), counters resync, and no window is emitted until (2,2) of the new frame. Stale rows are masked by the y gate.
- frame_done: asserted for exactly one cycle after the accepting edge of (IMG_W-1,IMG_H-1). It coincides with that pixel's win_valid.
- rst during an active frame: behaves as power-up reset. The next accepted pixel is (0,0) regardless of in_sof.
- Row wrap: x=0 and x=1 of every row emit no window. The left window columns carry previous-row data but are masked.
- No arithmetic beyond the counters. Counter widths are sized by clog2(IMG_W) and clog2(IMG_H); IMG_W/IMG_H need not be powers of two.

Test Plan:
Common setup for all scenarios: IMG_W=5, IMG_H=4, width=8, pixel value = 10*y+x.
1. Reset, then stream a full frame at in_valid=1 with in_sof on the first pixel.
   - First win_valid occurs one cycle after pixel (2,2), i.e. the 13th pixel.
   - That window is p11..p33 = 0,1,2,10,11,12,20,21,22.
   - Exactly 6 win_valid pulses in the frame.
2. Same frame, checking the row wrap.
   - Pixels (0,3) and (1,3) produce no win_valid.
   - Pixel (2,3) produces window 10,11,12,20,21,22,30,31,32.
   - Pixel (4,3) produces window 12,13,14,22,23,24,32,33,34 with frame_done=1 in the same cycle.
3. Random in_valid gaps (~50% duty) over a full frame.
   - Identical window sequence to scenario 1.
   - p** are stable and win_valid=0 during gap cycles.
4. Assert in_sof at pixel (3,2) of frame 1, then continue a clean frame.
   - No window is emitted until the new (2,2).
   - That window is 0,1,2,10,11,12,20,21,22.
5. Pulse rst after pixel (3,2), then stream a full frame without in_sof.
   - All outputs read 0 in the cycle after reset.
   - Windows match scenario 1 exactly.
6. Two back-to-back frames with no idle cycles.
   - 12 windows total; frame_done pulses exactly twice.
   - Frame 2's first window is 0,1,2,10,11,12,20,21,22.
